iso_clk_gen: RTL

Parametrised, glitch-free clock generator for the ISO7816-3 master. It derives the card clock (CLK pin) from the system clock with any integer period of 2 or more cycles, odd periods included. The divider can change on the fly with no zero-step procedure, and the generator supports the ISO7816 clock-stop feature, parking the card clock at a programmable level. Its rise/fall pre-pulses drive the ETU counter and the UART sampling logic.

---
 rtl/iso_clk_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/iso_clk_gen.sv
// iso_clk_gen: glitch-free card clock generator for the ISO7816-3 master.
// Produces a registered divided clock with any integer period >= 2 (odd
// periods split as ceil/floor low/high), on-the-fly period changes that take
// effect only at a toggle, and clock-stop parking at a programmable level.
// risingMatch/fallingMatch flag the cycle before each output edge.
module iso_clk_gen #(
  parameter int DIVIDER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIVIDER_WIDTH-1:0] divider,
  input  logic                     stopReq,
  input  logic                     stopLevel,
  output logic                     dividedClk,
  output logic                     risingMatch,
  output logic                     fallingMatch,
  output logic                     stopped,
  output logic [DIVIDER_WIDTH-1:0] curDivider
);

  typedef enum logic [1:0] {
    START   = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2
  } state_t;

  localparam logic [DIVIDER_WIDTH-1:0] MIN_PERIOD = DIVIDER_WIDTH'(2);
  localparam logic [DIVIDER_WIDTH-1:0] ONE        = DIVIDER_WIDTH'(1);

  state_t                   state_reg,   state_next;
  logic [DIVIDER_WIDTH-1:0] cnt_reg,     cnt_next;
  logic [DIVIDER_WIDTH-1:0] cur_div_reg, cur_div_next;
  logic                     clk_reg,     clk_next;
  logic                     stopped_reg, stopped_next;

  logic [DIVIDER_WIDTH-1:0] sanitized;
  logic [DIVIDER_WIDTH-1:0] half_cur;
  logic [DIVIDER_WIDTH-1:0] phase_len;
  logic                     match;

  // Periods below 2 cannot produce both a high and a low phase, so clamp.
  assign sanitized = (divider < MIN_PERIOD) ? MIN_PERIOD : divider;

  // High phase is floor(P/2); low phase takes the odd extra cycle. The
  // subtraction form keeps everything inside DIVIDER_WIDTH bits.
  assign half_cur  = cur_div_reg >> 1;
  assign phase_len = clk_reg ? half_cur : (cur_div_reg - half_cur);

  // Phase length is always >= 1 because the period is never below 2.
  assign match = (state_reg == RUN) && (cnt_reg == (phase_len - ONE));

  // State register and all datapath flops, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= START;
      cnt_reg     <= '0;
      cur_div_reg <= MIN_PERIOD;
      clk_reg     <= 1'b0;
      stopped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cur_div_reg <= cur_div_next;
      clk_reg     <= clk_next;
      stopped_reg <= stopped_next;
    end
  end

  // Next-state and datapath updates; the period only reloads at a toggle or
  // when (re)starting, so a running phase is never shortened or stretched.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cur_div_next = cur_div_reg;
    clk_next     = clk_reg;
    stopped_next = stopped_reg;

    unique case (state_reg)
      START: begin
        cur_div_next = sanitized;
        cnt_next     = '0;
        if (stopReq && !stopLevel) begin
          // Output is already low, so park immediately.
          state_next   = STOPPED;
          stopped_next = 1'b1;
        end else begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (match) begin
          clk_next     = ~clk_reg;
          cnt_next     = '0;
          cur_div_next = sanitized;
          if (stopReq && (~clk_reg == stopLevel)) begin
            state_next   = STOPPED;
            stopped_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end

      STOPPED: begin
        cnt_next = '0;
        if (!stopReq) begin
          // Resume with a full phase at the parked level.
          state_next   = RUN;
          cur_div_next = sanitized;
          stopped_next = 1'b0;
        end
      end

      default: begin
        state_next   = START;
        cnt_next     = '0;
        stopped_next = 1'b0;
      end
    endcase
  end

  assign dividedClk   = clk_reg;
  assign stopped      = stopped_reg;
  assign curDivider   = cur_div_reg;
  assign risingMatch  = match & ~clk_reg;
  assign fallingMatch = match &  clk_reg;

endmodule
